ifetch_stage: RTL and testbench
===============================

IFETCH_STAGE -- requirements
Module: ifetch_stage

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk_i  input  1  Clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  Synchronous active-high reset.
REQ-005 stall_i  input  1  Hold request from the decode hazard unit.
REQ-006 flush_i  input  1  Kill the instruction entering IF/ID.
REQ-007 redirect_i  input  1  Branch/jump taken; the PC loads redirect_pc_i.
REQ-008 redirect_pc_i  input  32  Redirect target address.
REQ-009 irom_addr_o  output  32  Fetch byte address to the asynchronous instruction ROM, which uses word index [15:2].
REQ-010 irom_inst_i  input  32  Instruction word returned combinationally by the ROM in the same cycle.
REQ-011 id_pc_o  output  32  Registered PC of the instruction in IF/ID.
REQ-012 id_pc4_o  output  32  Registered id_pc_o + 4.
REQ-013 id_inst_o  output  32  Registered instruction word.
REQ-014 id_valid_o  output  1  High when IF/ID holds a real instruction, low for a bubble.

Function
REQ-015 pc_q SHALL be a 32-bit register, and irom_addr_o SHALL equal pc_q combinationally with no added latency.
REQ-016 The next pc_q SHALL follow this priority: redirect_i gives {redirect_pc_i[31:2],2'b00}; otherwise stall_i holds pc_q; otherwise pc_q + 4.
REQ-017 Bits [1:0] of pc_q SHALL always be 2'b00; low bits of the redirect target are discarded.
REQ-018 pc_q + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC becomes 32'h0000_0000), and no flag SHALL be raised.
REQ-019 IF/ID SHALL load a bubble when redirect_i or flush_i is high, regardless of stall_i.
- Bubble values: id_valid_o=0, id_inst_o=32'h0000_0013 (NOP), id_pc_o=pc_q, id_pc4_o=pc_q+4.
REQ-020 When stall_i is high and redirect_i and flush_i are both low, IF/ID SHALL hold all four outputs unchanged.
REQ-021 In all other cases, IF/ID SHALL load id_pc_o=pc_q, id_pc4_o=pc_q+4, id_inst_o=irom_inst_i and id_valid_o=1.
REQ-022 When flush_i is high without redirect_i, the PC SHALL still follow REQ-016 (hold on stall, otherwise advance).
REQ-023 Fetch-to-decode latency SHALL be exactly one cycle: the word at pc_q in cycle N appears on id_inst_o in cycle N+1.
REQ-024 A redirect asserted in cycle N SHALL cause the target instruction to be fetched in cycle N+1 and to reach IF/ID in cycle N+2, with a single bubble in between.

Reset
REQ-025 While rst_i is high at a clock edge, the block SHALL set pc_q=RESET_PC, id_pc_o=RESET_PC, id_pc4_o=RESET_PC+4, id_inst_o=32'h0000_0013 and id_valid_o=0.
REQ-026 rst_i SHALL override stall_i, flush_i and redirect_i.
REQ-027 A reset asserted mid-stream SHALL discard any pending redirect or held instruction.
REQ-028 In the first cycle after rst_i deasserts, the block SHALL fetch RESET_PC, and id_valid_o SHALL rise in the following cycle unless that cycle is stalled, flushed or redirected.

Configuration
REQ-029 Macro IFETCH_PERF_CNT_EN, when defined, SHALL add two outputs: fetch_cnt_o (output, 32 bits) and stall_cnt_o (output, 32 bits).
REQ-030 fetch_cnt_o SHALL increment on each edge where IF/ID loads with id_valid_o=1.
REQ-031 stall_cnt_o SHALL increment on each edge where stall_i=1, redirect_i=0 and flush_i=0.
REQ-032 Both counters SHALL reset to 0 on rst_i and wrap modulo 2^32.
REQ-033 When IFETCH_PERF_CNT_EN is undefined, both ports and both counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Reset release, ROM preloaded with word=addr, 4 free cycles -> irom_addr_o 0,4,8,12; id_inst_o 0,4,8 from the second cycle; id_valid_o rises in cycle 2.
REQ-035 stall_i high 3 cycles at pc_q=8 -> pc_q stays 8, IF/ID holds pc 4 for 3 cycles, then sequencing resumes at 12.
REQ-036 redirect_i with redirect_pc_i=32'h0000_0103 at pc_q=16, same cycle as stall_i -> pc_q=32'h100 next cycle, one bubble (valid=0, inst=0x13), inst from 0x100 after that.
REQ-037 flush_i alone at pc_q=20 -> bubble in IF/ID, pc_q advances to 24; flush_i with stall_i -> bubble, pc_q stays 20.
REQ-038 RESET_PC=32'hFFFF_FFF8, 3 free cycles -> pc_q FFFF_FFF8, FFFF_FFFC, 0000_0000; id_pc4_o for FFFF_FFFC is 0.
REQ-039 With IFETCH_PERF_CNT_EN defined: 5 fetches, 2 stalls, 1 redirect, then rst_i mid-stream -> fetch_cnt_o=5 and stall_cnt_o=2 before reset, both 0 after reset.

Source files
------------

// File: rtl/ifetch_stage.sv
// Instruction fetch: PC register feeding an async ROM, plus the IF/ID pipeline register.
// Optional perf counters (fetch_cnt_o, stall_cnt_o) are built when IFETCH_PERF_CNT_EN is defined.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] irom_addr_o,
  input  logic [31:0] irom_inst_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        bubble;
  logic        load;
  logic        unused_low_bits;

  // Redirect targets are word aligned; the byte offset is dropped.
  assign unused_low_bits = ^redirect_pc_i[1:0];

  assign irom_addr_o = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign bubble      = redirect_i | flush_i;
  assign load        = ~bubble & ~stall_i;

  always_comb begin
    pc_next = pc_plus4;
    if (redirect_i)
      pc_next = {redirect_pc_i[31:2], 2'b00};
    else if (stall_i)
      pc_next = pc_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC_ALIGNED;
      id_pc_o    <= RESET_PC_ALIGNED;
      id_pc4_o   <= RESET_PC_ALIGNED + 32'd4;
      id_inst_o  <= NOP_INST;
      id_valid_o <= 1'b0;
    end else begin
      pc_q <= pc_next;
      if (bubble) begin
        id_pc_o    <= pc_q;
        id_pc4_o   <= pc_plus4;
        id_inst_o  <= NOP_INST;
        id_valid_o <= 1'b0;
      end else if (load) begin
        id_pc_o    <= pc_q;
        id_pc4_o   <= pc_plus4;
        id_inst_o  <= irom_inst_i;
        id_valid_o <= 1'b1;
      end
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_o <= 32'd0;
      stall_cnt_o <= 32'd0;
    end else begin
      if (load)
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (stall_i && !bubble)
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: directed scenarios plus randomized traffic against a cycle model.
module tb_ifetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1, stall = 1'b0, flush = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] irom_addr, irom_inst, id_pc, id_pc4, id_inst;
  logic        id_valid;
  logic [31:0] w_addr, w_inst, w_pc, w_pc4, w_id_inst;
  logic        w_valid;
  logic [31:0] rom [0:16383];
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, w_fetch_cnt, w_stall_cnt;
`endif

  int total = 0, bad = 0;

  logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_inst, m_fetch, m_stall;
  logic        m_valid;

  always #5 clk = ~clk;
  assign irom_inst = rom[irom_addr[15:2]];
  assign w_inst    = rom[w_addr[15:2]];

  ifetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .irom_addr_o(irom_addr), .irom_inst_i(irom_inst),
    .id_pc_o(id_pc), .id_pc4_o(id_pc4), .id_inst_o(id_inst), .id_valid_o(id_valid)
`ifdef IFETCH_PERF_CNT_EN
    , .fetch_cnt_o(fetch_cnt), .stall_cnt_o(stall_cnt)
`endif
  );

  ifetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_top (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .irom_addr_o(w_addr), .irom_inst_i(w_inst),
    .id_pc_o(w_pc), .id_pc4_o(w_pc4), .id_inst_o(w_id_inst), .id_valid_o(w_valid)
`ifdef IFETCH_PERF_CNT_EN
    , .fetch_cnt_o(w_fetch_cnt), .stall_cnt_o(w_stall_cnt)
`endif
  );

  // Reference: what one clock edge does to a fetch unit, straight from the behavioural rules.
  task automatic model_edge();
    logic [31:0] fetched;
    if (rst) begin
      m_pc = 32'h0; m_id_pc = 32'h0; m_id_pc4 = 32'h4; m_id_inst = 32'h13; m_valid = 1'b0;
      m_fetch = 0; m_stall = 0;
    end else begin
      fetched = rom[m_pc[15:2]];
      if (redirect || flush) begin
        m_id_pc = m_pc; m_id_pc4 = m_pc + 4; m_id_inst = 32'h13; m_valid = 1'b0;
      end else if (!stall) begin
        m_id_pc = m_pc; m_id_pc4 = m_pc + 4; m_id_inst = fetched; m_valid = 1'b1;
        m_fetch = m_fetch + 1;
      end else begin
        m_stall = m_stall + 1;
      end
      if (redirect)   m_pc = redirect_pc & 32'hFFFF_FFFC;
      else if (!stall) m_pc = m_pc + 4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b1; flush = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    step(); step();
    total++; if (irom_addr !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", irom_addr); end
    total++; if (id_pc !== 32'h0 || id_pc4 !== 32'h4) begin bad++; $display("FAIL reset_idpc got=%h/%h exp=0/4", id_pc, id_pc4); end
    total++; if (id_inst !== 32'h13 || id_valid !== 1'b0) begin bad++; $display("FAIL reset_inst got=%h/%b exp=13/0", id_inst, id_valid); end
    total++; if (w_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL reset_pc_param got=%h exp=fffffff8", w_addr); end
    stall = 1'b0; flush = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_sequential();
    rst = 1'b0;
    total++; if (irom_addr !== 32'h0) begin bad++; $display("FAIL seq_addr0 got=%h exp=0", irom_addr); end
    for (int i = 1; i <= 2; i++) begin
      step();
      total++; if (irom_addr !== 32'(4 * i)) begin bad++; $display("FAIL seq_addr got=%h exp=%h", irom_addr, 4 * i); end
      total++; if (id_inst !== 32'(4 * (i - 1)) || id_valid !== 1'b1) begin
        bad++; $display("FAIL seq_inst got=%h/%b exp=%h/1", id_inst, id_valid, 4 * (i - 1)); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (irom_addr !== 32'h8 || id_pc !== 32'h4 || id_inst !== 32'h4 || id_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold got pc=%h idpc=%h inst=%h v=%b exp 8/4/4/1", irom_addr, id_pc, id_inst, id_valid); end
    end
    stall = 1'b0;
    step();
    total++; if (irom_addr !== 32'hC || id_pc !== 32'h8 || id_inst !== 32'h8) begin
      bad++; $display("FAIL stall_resume got pc=%h idpc=%h inst=%h exp c/8/8", irom_addr, id_pc, id_inst); end
    step();
  endtask

  task automatic test_redirect();
    total++; if (irom_addr !== 32'h10) begin bad++; $display("FAIL redir_pre got=%h exp=10", irom_addr); end
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0; stall = 1'b0;
    total++; if (irom_addr !== 32'h100) begin bad++; $display("FAIL redir_pc got=%h exp=100", irom_addr); end
    total++; if (id_valid !== 1'b0 || id_inst !== 32'h13 || id_pc !== 32'h10 || id_pc4 !== 32'h14) begin
      bad++; $display("FAIL redir_bubble got v=%b inst=%h pc=%h pc4=%h exp 0/13/10/14", id_valid, id_inst, id_pc, id_pc4); end
    step();
    total++; if (id_valid !== 1'b1 || id_inst !== 32'h100 || id_pc !== 32'h100 || irom_addr !== 32'h104) begin
      bad++; $display("FAIL redir_target got v=%b inst=%h pc=%h addr=%h exp 1/100/100/104", id_valid, id_inst, id_pc, irom_addr); end
  endtask

  task automatic test_flush();
    redirect = 1'b1; redirect_pc = 32'h14;
    step();
    redirect = 1'b0; flush = 1'b1;
    step();
    total++; if (id_valid !== 1'b0 || id_inst !== 32'h13 || id_pc !== 32'h14 || irom_addr !== 32'h18) begin
      bad++; $display("FAIL flush_alone got v=%b inst=%h pc=%h addr=%h exp 0/13/14/18", id_valid, id_inst, id_pc, irom_addr); end
    flush = 1'b0; redirect = 1'b1;
    step();
    redirect = 1'b0; flush = 1'b1; stall = 1'b1;
    step();
    total++; if (id_valid !== 1'b0 || id_inst !== 32'h13 || id_pc !== 32'h14 || irom_addr !== 32'h14) begin
      bad++; $display("FAIL flush_stall got v=%b inst=%h pc=%h addr=%h exp 0/13/14/14", id_valid, id_inst, id_pc, irom_addr); end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_wrap();
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (w_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_pc0 got=%h exp=fffffff8", w_addr); end
    step();
    total++; if (w_addr !== 32'hFFFF_FFFC || w_pc !== 32'hFFFF_FFF8) begin
      bad++; $display("FAIL wrap_pc1 got=%h/%h exp=fffffffc/fffffff8", w_addr, w_pc); end
    step();
    total++; if (w_addr !== 32'h0 || w_pc !== 32'hFFFF_FFFC || w_pc4 !== 32'h0) begin
      bad++; $display("FAIL wrap_pc2 got=%h idpc=%h pc4=%h exp=0/fffffffc/0", w_addr, w_pc, w_pc4); end
  endtask

`ifdef IFETCH_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1; step(); rst = 1'b0;
    repeat (5) step();
    stall = 1'b1; repeat (2) step(); stall = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h200; step(); redirect = 1'b0;
    total++; if (fetch_cnt !== 32'd5 || stall_cnt !== 32'd2) begin
      bad++; $display("FAIL perf_counts got=%0d/%0d exp=5/2", fetch_cnt, stall_cnt); end
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      bad++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", fetch_cnt, stall_cnt); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 16384; i++) rom[i] = $urandom;
    rst = 1'b1; step(); rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 60) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      redirect = ($urandom_range(0, 7) == 0);
      redirect_pc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step();
      total++; if (irom_addr !== m_pc || id_pc !== m_id_pc || id_pc4 !== m_id_pc4 ||
                   id_inst !== m_id_inst || id_valid !== m_valid) begin
        bad++;
        $display("FAIL rand_cycle%0d got pc=%h idpc=%h pc4=%h inst=%h v=%b exp %h/%h/%h/%h/%b", n,
                 irom_addr, id_pc, id_pc4, id_inst, id_valid, m_pc, m_id_pc, m_id_pc4, m_id_inst, m_valid);
      end
`ifdef IFETCH_PERF_CNT_EN
      total++; if (fetch_cnt !== m_fetch || stall_cnt !== m_stall) begin
        bad++; $display("FAIL rand_perf%0d got=%0d/%0d exp=%0d/%0d", n, fetch_cnt, stall_cnt, m_fetch, m_stall); end
`endif
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) rom[i] = 32'(i) << 2;
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_flush();
    test_wrap();
`ifdef IFETCH_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
